// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
//   state_e     - sequencer FSM encoding
//   cnt_width() - width of the shared cycle counter for the largest bound
//   SYNC_STAGES - depth of the LOCK synchronizer
package pll_seq_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    STABLE,
    READY,
    LOST,
    RESTART,
    FAIL
  } state_e;

  // One spare bit over $clog2(max) so count values up to max are representable.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: flop-chain synchronizer for the asynchronous PLL LOCK input.
//   CLK_i - reference clock
//   RST_i - synchronous active-high reset, clears the chain
//   d_i   - asynchronous input
//   q_o   - synchronized output, SYNC_STAGES cycles behind d_i
module sync_2ff
  import pll_seq_pkg::*;
(
  input  logic CLK_i,
  input  logic RST_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK_i) begin
    if (RST_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up a PLL, qualifies its LOCK, releases reset to
// downstream logic, and power-cycles the PLL on timeout (bounded) or on loss.
//   CLK_i        - PLL reference clock
//   RST_i        - synchronous active-high reset
//   START_i      - level request; low returns to IDLE
//   LOCK_i       - PLL lock (asynchronous)
//   PLL_EN_o     - PLL enable
//   RST_OUT_o    - active-high reset for logic on the PLL output clocks
//   READY_o      - PLL qualified locked, RST_OUT_o released
//   FAIL_o       - timeout retries exhausted
//   LOSS_SEEN_o  - sticky: lock lost after READY (cleared by RST_i only)
//   RETRY_CNT_o  - timeout retries used in this bring-up
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int OFF_CYCLES    = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       CLK_i,
  input  logic       RST_i,
  input  logic       START_i,
  input  logic       LOCK_i,
  output logic       PLL_EN_o,
  output logic       RST_OUT_o,
  output logic       READY_o,
  output logic       FAIL_o,
  output logic       LOSS_SEEN_o,
  output logic [3:0] RETRY_CNT_o
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, OFF_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .CLK_i (CLK_i),
    .RST_i (RST_i),
    .d_i   (LOCK_i),
    .q_o   (lock_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          loss_q, loss_d;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // One counter shared by WAIT_LOCK / STABLE / RESTART; every exit clears it,
  // and each state leaves at its own bound, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!START_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          retry_d = '0;
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + CW'(1);
          if (lock_s) begin
            // lock wins over a timeout landing in the same cycle
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              state_d = RESTART;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = FAIL;
            end
          end
        end
        STABLE: begin
          cnt_d = cnt_q + CW'(1);
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == ST_LAST) begin
            state_d = READY;
            cnt_d   = '0;
          end
        end
        READY: begin
          if (!lock_s) state_d = LOST;
        end
        LOST: begin
          // loss-driven restart gets a fresh retry budget
          state_d = RESTART;
          cnt_d   = '0;
          retry_d = '0;
          loss_d  = 1'b1;
        end
        RESTART: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == OFF_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign PLL_EN_o    = (state_q == WAIT_LOCK) || (state_q == STABLE) ||
                       (state_q == READY)     || (state_q == LOST);
  assign RST_OUT_o   = (state_q != READY);
  assign READY_o     = (state_q == READY);
  assign FAIL_o      = (state_q == FAIL);
  assign LOSS_SEEN_o = loss_q;
  assign RETRY_CNT_o = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, OFF_CYCLES=4, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       LOCK = 1'b0;
  logic       PLL_EN, RST_OUT, READY, FAIL, LOSS_SEEN;
  logic [3:0] RETRY_CNT;

  int tests = 0;
  int fails = 0;

  pll_lock_sequencer #(
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .OFF_CYCLES   (4),
    .MAX_RETRIES  (2)
  ) dut (
    .CLK_i       (CLK),
    .RST_i       (RST),
    .START_i     (START),
    .LOCK_i      (LOCK),
    .PLL_EN_o    (PLL_EN),
    .RST_OUT_o   (RST_OUT),
    .READY_o     (READY),
    .FAIL_o      (FAIL),
    .LOSS_SEEN_o (LOSS_SEEN),
    .RETRY_CNT_o (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  // advance n clocks; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; LOCK = 1'b0;
    tick(3);
    tests++;
    if ({PLL_EN, RST_OUT, READY, FAIL, LOSS_SEEN, RETRY_CNT} !== 9'b0_1_0_0_0_0000) begin
      fails++;
      $display("FAIL reset_values got=%b exp=%b", {PLL_EN, RST_OUT, READY, FAIL, LOSS_SEEN, RETRY_CNT}, 9'b010000000);
    end
    RST = 1'b0;
  endtask

  // scenario 1: lock 10 cycles after enable, READY 11 cycles after LOCK
  task automatic test_lock_up;
    START = 1'b1;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b110) begin
      fails++; $display("FAIL bringup_enable got=%b exp=110", {PLL_EN, RST_OUT, READY});
    end
    tick(10);
    LOCK = 1'b1;
    tick(10);
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b110) begin
      fails++; $display("FAIL bringup_early_ready got=%b exp=110", {PLL_EN, RST_OUT, READY});
    end
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b101) begin
      fails++; $display("FAIL bringup_ready got=%b exp=101", {PLL_EN, RST_OUT, READY});
    end
  endtask

  // scenario 2: no lock -> 32 on / 4 off / 32 on / 4 off / 32 on, then FAIL
  task automatic test_timeout;
    logic exp_en;
    START = 1'b0; LOCK = 1'b0;
    tick(3);
    START = 1'b1;
    for (int i = 1; i <= 104; i++) begin
      tick();
      exp_en = (i <= 32) || (i >= 37 && i <= 68) || (i >= 73);
      tests++;
      if (PLL_EN !== exp_en) begin
        fails++; $display("FAIL timeout_pll_en cycle=%0d got=%b exp=%b", i, PLL_EN, exp_en);
      end
      if (i == 33 || i == 69) begin
        tests++;
        if (RETRY_CNT !== ((i == 33) ? 4'd1 : 4'd2)) begin
          fails++; $display("FAIL timeout_retry cycle=%0d got=%0d exp=%0d", i, RETRY_CNT, (i == 33) ? 1 : 2);
        end
      end
    end
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, FAIL, RETRY_CNT} !== {3'b011, 4'd2}) begin
      fails++; $display("FAIL timeout_fail got=%b exp=%b", {PLL_EN, RST_OUT, FAIL, RETRY_CNT}, {3'b011, 4'd2});
    end
    tick(3);
    tests++;
    if ({PLL_EN, FAIL} !== 2'b01) begin
      fails++; $display("FAIL fail_held got=%b exp=01", {PLL_EN, FAIL});
    end
    START = 1'b0;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, FAIL} !== 3'b010) begin
      fail_clear_msg();
    end
  endtask

  task automatic fail_clear_msg;
    fails++;
    $display("FAIL fail_clear got=%b exp=010", {PLL_EN, RST_OUT, FAIL});
  endtask

  // scenario 3: one-cycle LOCK glitch at STABLE count 5 sends it back to WAIT_LOCK
  task automatic test_glitch;
    START = 1'b1;
    tick();                      // e1: WAIT_LOCK
    LOCK = 1'b1;
    tick(6);                     // e7
    LOCK = 1'b0;
    tick();                      // e8
    LOCK = 1'b1;
    tick(2);                     // e10: back in WAIT_LOCK
    tests++;
    if ({PLL_EN, RETRY_CNT} !== {1'b1, 4'd0}) begin
      fails++; $display("FAIL glitch_retry got=%b exp=%b", {PLL_EN, RETRY_CNT}, {1'b1, 4'd0});
    end
    tick(2);                     // e12: unglitched path would be READY here
    tests++;
    if (READY !== 1'b0) begin
      fails++; $display("FAIL glitch_no_early_ready got=%b exp=0", READY);
    end
    tick(6);                     // e18
    tests++;
    if (READY !== 1'b0) begin
      fails++; $display("FAIL glitch_ready_minus1 got=%b exp=0", READY);
    end
    tick();                      // e19 = 11 after LOCK high again
    tests++;
    if ({READY, RST_OUT, RETRY_CNT} !== {2'b10, 4'd0}) begin
      fails++; $display("FAIL glitch_ready got=%b exp=%b", {READY, RST_OUT, RETRY_CNT}, {2'b10, 4'd0});
    end
  endtask

  // scenario 4: loss of lock while READY
  task automatic test_loss;
    LOCK = 1'b0;
    tick(2);
    tests++;
    if (READY !== 1'b1) begin
      fails++; $display("FAIL loss_ready_kept got=%b exp=1", READY);
    end
    tick();                      // LOST
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b110) begin
      fails++; $display("FAIL loss_lost_cycle got=%b exp=110", {PLL_EN, RST_OUT, READY});
    end
    tick();                      // RESTART
    tests++;
    if ({PLL_EN, RST_OUT, LOSS_SEEN, RETRY_CNT} !== {3'b011, 4'd0}) begin
      fails++; $display("FAIL loss_restart got=%b exp=%b", {PLL_EN, RST_OUT, LOSS_SEEN, RETRY_CNT}, {3'b011, 4'd0});
    end
    LOCK = 1'b1;
    tick(3);
    tests++;
    if (PLL_EN !== 1'b0) begin
      fails++; $display("FAIL loss_off_last got=%b exp=0", PLL_EN);
    end
    tick();
    tests++;
    if (PLL_EN !== 1'b1) begin
      fails++; $display("FAIL loss_reenable got=%b exp=1", PLL_EN);
    end
    tick(8);
    tests++;
    if (READY !== 1'b0) begin
      fails++; $display("FAIL loss_relock_early got=%b exp=0", READY);
    end
    tick();
    tests++;
    if ({READY, LOSS_SEEN} !== 2'b11) begin
      fails++; $display("FAIL loss_relock_ready got=%b exp=11", {READY, LOSS_SEEN});
    end
  endtask

  // scenario 5: START drop in READY, STABLE and RESTART; RST mid-READY
  task automatic test_start_drop;
    int k;
    START = 1'b0;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b010) begin
      fails++; $display("FAIL drop_in_ready got=%b exp=010", {PLL_EN, RST_OUT, READY});
    end
    START = 1'b1;
    tick(4);                     // WAIT_LOCK, then STABLE cnt 0..2
    START = 1'b0;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b010) begin
      fails++; $display("FAIL drop_in_stable got=%b exp=010", {PLL_EN, RST_OUT, READY});
    end
    START = 1'b1;
    tick(10);                    // WAIT_LOCK, STABLE, READY after 8 in STABLE
    tests++;
    if (READY !== 1'b1) begin
      fails++; $display("FAIL drop_reready got=%b exp=1", READY);
    end
    LOCK = 1'b0;
    tick(4);                     // LOST then RESTART cnt 0
    START = 1'b0;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY} !== 3'b010) begin
      fails++; $display("FAIL drop_in_restart got=%b exp=010", {PLL_EN, RST_OUT, READY});
    end
    START = 1'b1;
    tick();                      // IDLE -> WAIT_LOCK; a stuck RESTART would keep it low
    tests++;
    if (PLL_EN !== 1'b1) begin
      fails++; $display("FAIL drop_restart_to_idle got=%b exp=1", PLL_EN);
    end
    LOCK = 1'b1;
    k = 0;
    while (READY !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    tests++;
    if (READY !== 1'b1) begin
      fails++; $display("FAIL rst_setup_ready got=%b exp=1 after %0d cycles", READY, k);
    end
    RST = 1'b1;
    tick();
    tests++;
    if ({PLL_EN, RST_OUT, READY, FAIL, LOSS_SEEN, RETRY_CNT} !== 9'b010000000) begin
      fails++; $display("FAIL rst_mid_ready got=%b exp=010000000", {PLL_EN, RST_OUT, READY, FAIL, LOSS_SEEN, RETRY_CNT});
    end
    START = 1'b0; LOCK = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  // scenario 6: lock arriving on the timeout cycle wins; one cycle later does not
  task automatic test_lock_priority;
    START = 1'b0; LOCK = 1'b0;
    tick(3);
    START = 1'b1;
    tick();                      // w
    tick(30);                    // w+30: LOCK one cycle too late
    LOCK = 1'b1;
    tick(2);                     // w+32
    tests++;
    if ({PLL_EN, RETRY_CNT} !== {1'b0, 4'd1}) begin
      fails++; $display("FAIL late_lock_restart got=%b exp=%b", {PLL_EN, RETRY_CNT}, {1'b0, 4'd1});
    end
    LOCK = 1'b0;
    tick(4);                     // w2: WAIT_LOCK
    tests++;
    if (PLL_EN !== 1'b1) begin
      fails++; $display("FAIL late_lock_rewait got=%b exp=1", PLL_EN);
    end
    tick(29);                    // w2+29
    LOCK = 1'b1;
    tick(3);                     // w2+32: lock_s high with cnt==31
    tests++;
    if ({PLL_EN, READY, RETRY_CNT} !== {2'b10, 4'd1}) begin
      fails++; $display("FAIL lock_priority got=%b exp=%b", {PLL_EN, READY, RETRY_CNT}, {2'b10, 4'd1});
    end
    tick(8);
    tests++;
    if ({READY, RST_OUT, RETRY_CNT} !== {2'b10, 4'd1}) begin
      fails++; $display("FAIL lock_priority_ready got=%b exp=%b", {READY, RST_OUT, RETRY_CNT}, {2'b10, 4'd1});
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_timeout();
    test_glitch();
    test_loss();
    test_start_drop();
    test_lock_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
